// File: rtl/root_mul.sv
// ---------------------------------------------------------------------------
// root_mul
//   Computes result = a * floor(root(b)) for an unsigned multiplicand a and an
//   unsigned radicand b. The root is a square root (mode_i = 1) or a cube root
//   (mode_i = 0). The root is found bit-serially, MSB first, by restoring trial
//   (one root bit per ROOT cycle). It is then multiplied by a using shift-add,
//   consuming one root bit per MUL cycle.
//
//   Sequence: IDLE -> LOAD (1 cycle) -> ROOT (R cycles) -> MUL (RW cycles)
//             -> IDLE.
//   RW = ceil(W/2). R = RW for square root, R = ceil(W/3) for cube root.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : request; accepted only in IDLE (busy low)
//   mode_i  : 1 = square root, 0 = cube root (latched at acceptance)
//   a_i     : multiplicand, W bits (latched at acceptance)
//   b_i     : radicand, W bits (latched at acceptance)
//   busy    : high while an operation is in progress
//   done    : one-cycle pulse when result updates
//   result  : a * floor(root(b)), W+RW bits, held between completions
//
// Configuration macro
//   ROOT_MUL_ZERO_SKIP_EN : when defined, the MUL phase is skipped if the
//   latched a or the computed root is zero. result becomes 0 and done still
//   pulses.
// ---------------------------------------------------------------------------
module root_mul #(
    parameter int unsigned W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode_i,
    input  logic [W-1:0]               a_i,
    input  logic [W-1:0]               b_i,
    output logic                       busy,
    output logic                       done,
    output logic [W+(W+1)/2-1:0]       result
);

    localparam int unsigned RW  = (W + 1) / 2;   // root width / square-root cycles
    localparam int unsigned R3  = (W + 2) / 3;   // cube-root cycles
    localparam int unsigned PW  = W + RW;        // product width
    localparam int unsigned TW  = 3 * RW;        // width holding trial^3 exactly
    localparam int unsigned CW  = $clog2(RW + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROOT,
        MUL
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            mode_q;
    logic [RW-1:0]   root_q;
    logic [PW-1:0]   mcand_q;
    logic [PW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;

    logic [RW-1:0]   trial;
    logic [TW-1:0]   trial_ext;
    logic [TW-1:0]   trial_sq;
    logic [TW-1:0]   trial_cb;
    logic [TW-1:0]   trial_pow;
    logic [RW-1:0]   root_nxt;
    logic [PW-1:0]   acc_nxt;
    logic            cnt_zero;
    logic            skip;

    assign busy     = (state_q != IDLE);
    assign cnt_zero = (cnt_q == '0);

    // Restoring trial: tentatively set the current root bit. Keep it only
    // if trial^k still fits under the radicand. Otherwise the previous root
    // is kept (restored).
    always_comb begin
        trial     = root_q | (RW'(1) << cnt_q);
        trial_ext = TW'(trial);
        trial_sq  = trial_ext * trial_ext;
        trial_cb  = trial_sq * trial_ext;
        trial_pow = mode_q ? trial_sq : trial_cb;
        root_nxt  = (trial_pow <= TW'(b_q)) ? trial : root_q;
    end

    // Shift-add step: root_q is consumed LSB first while the multiplicand
    // shifts left.
    always_comb begin
        acc_nxt = acc_q;
        if (root_q[0]) begin
            acc_nxt = acc_q + mcand_q;
        end
    end

`ifdef ROOT_MUL_ZERO_SKIP_EN
    always_comb begin
        skip = (state_q == ROOT) && cnt_zero &&
               ((a_q == '0) || (root_nxt == '0));
    end
`else
    assign skip = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = ROOT;
            end
            ROOT: begin
                if (cnt_zero) begin
                    state_d = skip ? IDLE : MUL;
                end
            end
            MUL: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            root_q  <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q    <= a_i;
                        b_q    <= b_i;
                        mode_q <= mode_i;
                    end
                end
                LOAD: begin
                    root_q  <= '0;
                    acc_q   <= '0;
                    mcand_q <= PW'(a_q);
                    cnt_q   <= mode_q ? CW'(RW - 1) : CW'(R3 - 1);
                end
                ROOT: begin
                    root_q <= root_nxt;
                    if (cnt_zero) begin
                        cnt_q <= CW'(RW - 1);
                        if (skip) begin
                            result <= '0;
                            done   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                MUL: begin
                    acc_q   <= acc_nxt;
                    mcand_q <= mcand_q << 1;
                    root_q  <= root_q >> 1;
                    if (cnt_zero) begin
                        result <= acc_nxt;
                        done   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    root_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_root_mul.sv
// ---------------------------------------------------------------------------
// tb_root_mul
//   Scoreboard testbench for root_mul (W = 8).
//   At acceptance, the expected result and busy length are pushed to a queue.
//   On each done pulse the monitor pops the queue and compares. Define
//   ROOT_MUL_ZERO_SKIP_EN for both bench and RTL to exercise the skip build.
// ---------------------------------------------------------------------------
module tb_root_mul;

    localparam int W     = 8;
    localparam int RW    = (W + 1) / 2;
    localparam int RES_W = W + RW;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode_i;
    logic [W-1:0]     a_i;
    logic [W-1:0]     b_i;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;

    typedef struct {
        int unsigned res;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned busy_cnt = 0;
    logic [RES_W-1:0] last_res = '0;

    root_mul #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode_i (mode_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned model_root(input bit m, input int unsigned b);
        int unsigned k = 0;
        if (m) begin
            while ((k + 1) * (k + 1) <= b) k++;
        end else begin
            while ((k + 1) * (k + 1) * (k + 1) <= b) k++;
        end
        return k;
    endfunction

    function automatic exp_t model(input bit m, input int unsigned a, input int unsigned b);
        exp_t e;
        int unsigned r;
        int unsigned rc;
        r     = model_root(m, b);
        rc    = m ? RW : (W + 2) / 3;
        e.res = a * r;
        e.lat = 1 + rc + RW;
`ifdef ROOT_MUL_ZERO_SKIP_EN
        if (a == 0 || r == 0) e.lat = 1 + rc;
`endif
        return e;
    endfunction

    // Monitor: counts busy cycles, scores each done pulse, checks result hold.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt = 0;
            last_res = '0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check_val("spurious_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("result", 32'(result), e.res);
                    check_val("busy_cycles", busy_cnt, e.lat);
                end
                busy_cnt = 0;
                last_res = result;
            end else begin
                check_val("result_hold", 32'(result), 32'(last_res));
            end
        end
    end

    // Issue a request at a negedge once busy is low; scrambles inputs afterwards.
    task automatic issue(input bit m, input int unsigned a, input int unsigned b);
        int guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) check_val("issue_timeout", 32'(busy), 32'd0);
        mode_i = m;
        a_i    = W'(a);
        b_i    = W'(b);
        start  = 1'b1;
        sb.push_back(model(m, a, b));
        @(negedge clk);
        start  = 1'b0;
        a_i    = W'($urandom);
        b_i    = W'($urandom);
        mode_i = 1'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || busy) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            check_val("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int guard;
        rst    = 1'b1;
        start  = 1'b0;
        mode_i = 1'b0;
        a_i    = '0;
        b_i    = '0;
        #2;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_result", 32'(result), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        issue(1'b0, 5, 27);    drain();
        issue(1'b1, 200, 255); drain();
        issue(1'b0, 255, 255); drain();
        issue(1'b1, 77, 0);    drain();
        issue(1'b1, 0, 50);    drain();
        issue(1'b1, 2, 50);    drain();
        issue(1'b0, 9, 7);     drain();
        issue(1'b0, 13, 8);    drain();

        // Start while busy is ignored; start in done cycle accepted with no gap
        issue(1'b1, 3, 100);
        @(negedge clk);
        start  = 1'b1;
        a_i    = 8'd7;
        b_i    = 8'd9;
        mode_i = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        guard  = 0;
        while (!done && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_val("done_seen", 32'(done), 32'd1);
        issue(1'b0, 2, 64);
        check_val("no_gap_busy", 32'(busy), 32'd1);
        drain();

        // Reset mid-operation
        issue(1'b1, 9, 200);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_result", 32'(result), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_val("abort_idle", 32'(busy), 32'd0);
        issue(1'b1, 9, 200);   drain();

        // Random back-to-back traffic
        for (int i = 0; i < 30; i++) begin
            int unsigned ra;
            int unsigned rb;
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            if (i % 7 == 0) ra = 0;
            if (i % 5 == 0) rb = 255;
            issue(1'($urandom), ra, rb);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/root_mul.md
ROOT_MUL -- requirements
Module: root_mul

Interface
REQ-001 Parameter W, default 8, operand width in bits (W >= 3).
REQ-002 Derived constants: RW = ceil(W/2) (root width); R = ceil(W/2) when mode is square root; R = ceil(W/3) when mode is cube root.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; accepted only when sampled high while busy is low.
REQ-006 mode_i  input  1  root select: 0 = cube root, 1 = square root; sampled at acceptance.
REQ-007 a_i  input  W  multiplicand, unsigned; sampled at acceptance.
REQ-008 b_i  input  W  radicand, unsigned; sampled at acceptance.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking a result update.
REQ-011 result  output  W+RW  a * floor(root(b)), unsigned.

Function
REQ-012 The block SHALL compute result = a_i * floor(b_i^(1/2)) when mode_i=1, and a_i * floor(b_i^(1/3)) when mode_i=0, exactly, with no truncation.
REQ-013 The FSM SHALL have states IDLE, LOAD, ROOT, MUL; IDLE->LOAD on accepted start; LOAD->ROOT after 1 cycle; ROOT->MUL after exactly R cycles; MUL->IDLE after exactly RW cycles.
REQ-014 The root SHALL be computed bit-serially, one root bit per ROOT cycle, MSB first, restoring method.
REQ-015 The product SHALL be computed shift-add, one root bit per MUL cycle.
REQ-016 busy SHALL be combinationally (state != IDLE); with acceptance at edge T0, busy SHALL be high for exactly 1+R+RW cycles.
REQ-017 On the MUL->IDLE edge, result SHALL load the product and done SHALL be 1 for exactly the following cycle.
REQ-018 result SHALL hold its value between completions; done SHALL be 0 at all other times.
REQ-019 start while busy=1 SHALL be ignored with no effect on operands, mode or timing.
REQ-020 start high in the done cycle SHALL be accepted (busy is 0); back-to-back operations SHALL have no idle gap beyond that cycle.
REQ-021 Changes on a_i, b_i and mode_i after acceptance SHALL not affect the running operation.
REQ-022 b_i=0 or a_i=0 SHALL yield result 0 with normal latency (macro absent).

Reset
REQ-023 rst high SHALL force state IDLE, busy=0, done=0, result=0, and clear all internal operand, root and accumulator registers, without waiting for clk.
REQ-024 rst asserted mid-operation SHALL abort it; no done pulse, result=0; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro ROOT_MUL_ZERO_SKIP_EN defined: if the latched a is 0 or the computed root is 0, the FSM SHALL go ROOT->IDLE, skipping MUL; result=0, done pulses, busy high exactly 1+R cycles.
REQ-026 Macro ROOT_MUL_ZERO_SKIP_EN undefined: latency SHALL be fixed at 1+R+RW busy cycles for all operands.

Verification (W=8, RW=4, macro undefined unless stated)
REQ-027 mode=0, a=5, b=27 -> result=15, busy high 8 cycles, done in 9th cycle after acceptance.
REQ-028 mode=1, a=200, b=255 -> result=3000, busy high 9 cycles; mode=0, a=255, b=255 -> result=1530.
REQ-029 mode=1, a=3, b=100, start re-pulsed with a=7, b=9 while busy -> result=30, second request ignored; start held during done cycle with a=2, b=64, mode=0 -> next result=8.
REQ-030 mode=1, a=9, b=200, rst pulsed at 4th busy cycle -> busy=0, result=0, no done pulse; next start a=9, b=200 -> result=126.
REQ-031 ROOT_MUL_ZERO_SKIP_EN defined: mode=1, a=77, b=0 -> result=0, busy high 5 cycles; mode=1, a=0, b=50 -> result=0, busy high 5 cycles; mode=1, a=2, b=50 -> result=14, busy high 9 cycles.
